// File: rtl/cdm_pkg.sv
// Shared types and widths for the carry-disregard 8x8 sequencer and its 8x4 core.
// Pure declarations; no logic, no latency.
package cdm_pkg;

  localparam int OPA_W  = 8;
  localparam int NIB_W  = 4;
  localparam int CORE_W = 12;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cdm_seq8x8_if.sv
// Operand/result valid-ready bundle between producer, sequencer and consumer.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface cdm_seq8x8_if;
  import cdm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPA_W-1:0]  in_a;
  logic [OPA_W-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_p;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

endinterface

// File: rtl/cd_core_8x4.sv
// Combinational 8x4 carry-disregard multiplier core, 12-bit result, zero latency.
// Rows 1-2 fold in by XOR; row 3 uses XOR below column 9 and a half-adder chain above.
module cd_core_8x4
  import cdm_pkg::*;
(
  input  logic [OPA_W-1:0]  a_i,
  input  logic [NIB_W-1:0]  b_i,
  output logic [CORE_W-1:0] p_o
);

  logic [OPA_W-1:0] pp0, pp1, pp2, pp3;
  logic [8:0]       sum01;
  logic [9:0]       sum012;
  logic [8:0]       low;
  logic             s9, c9, s10, c10;

  always_comb begin
    pp0 = a_i & {OPA_W{b_i[0]}};
    pp1 = a_i & {OPA_W{b_i[1]}};
    pp2 = a_i & {OPA_W{b_i[2]}};
    pp3 = a_i & {OPA_W{b_i[3]}};

    sum01  = {1'b0, pp0} ^ {pp1, 1'b0};
    sum012 = {1'b0, sum01} ^ {pp2, 2'b00};

    // Only the top two columns of row 3 keep their carries; c10 becomes bit 11.
    low = sum012[8:0] ^ {pp3[5:0], 3'b000};
    s9  = sum012[9] ^ pp3[6];
    c9  = sum012[9] & pp3[6];
    s10 = pp3[7] ^ c9;
    c10 = pp3[7] & c9;

    p_o = {c10, s10, s9, low};
  end

endmodule

// File: rtl/cdm_seq8x8.sv
// Approximate 8x8 multiply by running one 8x4 carry-disregard core over each B nibble.
// Latency 0-2 cycles after accept; result held in DONE until out_ready, in_ready only in IDLE.
module cdm_seq8x8
  import cdm_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  cdm_seq8x8_if.slave       bus,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e             state_q, state_d;
  logic [OPA_W-1:0]   a_q, a_d;
  logic [OPA_W-1:0]   b_q, b_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0]  out_p_q, out_p_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic [NIB_W-1:0]   core_b;
  logic [CORE_W-1:0]  core_p;

  assign core_b = (state_q == HI) ? b_q[OPA_W-1:NIB_W] : b_q[NIB_W-1:0];

  cd_core_8x4 u_core (
    .a_i (a_q),
    .b_i (core_b),
    .p_o (core_p)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.in_a;
          b_d   = bus.in_b;
          acc_d = '0;
          if (!SKIP_ZERO)
            state_d = LO;
          else if (bus.in_b == '0)
            state_d = DONE;
          else if (bus.in_b[NIB_W-1:0] == '0)
            state_d = HI;
          else
            state_d = LO;
        end
      end
      LO: begin
        acc_d   = PROD_W'(core_p);
        state_d = (SKIP_ZERO && (b_q[OPA_W-1:NIB_W] == '0)) ? DONE : HI;
      end
      HI: begin
        acc_d   = acc_q + (PROD_W'(core_p) << NIB_W);
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (op_count_q != '1)
            op_count_d = op_count_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load the result on the edge that enters DONE, whichever state we came from.
    if ((state_d == DONE) && (state_q != DONE)) begin
      out_p_d     = acc_d;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign busy          = (state_q != IDLE);
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_cdm_seq8x8.sv
// Directed bench for cdm_seq8x8: one instance with zero-skip, one without, shared clock/reset.
module tb_cdm_seq8x8;

  typedef struct {
    bit          s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, vld, ordy;
  logic [7:0]  a_in, b_in;
  logic        busy1, busy0;
  logic [15:0] cnt1, cnt0;
  logic        o_vld, o_rdy_in, o_busy;
  logic [15:0] o_p, o_cnt;
  int          errors = 0;
  int          checks = 0;
  int          exp1 = 0;
  int          exp0 = 0;
  vec_t        vecs[12];

  cdm_seq8x8_if if1 ();
  cdm_seq8x8_if if0 ();

  cdm_seq8x8 #(.SKIP_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1), .op_count(cnt1)
  );
  cdm_seq8x8 #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0), .op_count(cnt0)
  );

  always #5 clk = ~clk;

  assign if1.in_valid  = sel & vld;
  assign if0.in_valid  = ~sel & vld;
  assign if1.out_ready = sel & ordy;
  assign if0.out_ready = ~sel & ordy;
  assign if1.in_a = a_in;
  assign if1.in_b = b_in;
  assign if0.in_a = a_in;
  assign if0.in_b = b_in;

  assign o_vld    = sel ? if1.out_valid : if0.out_valid;
  assign o_p      = sel ? if1.out_p     : if0.out_p;
  assign o_rdy_in = sel ? if1.in_ready  : if0.in_ready;
  assign o_busy   = sel ? busy1         : busy0;
  assign o_cnt    = sel ? cnt1          : cnt0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_vld && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p, input int lat, input string tag);
    int n;
    sel = s; a_in = a; b_in = b; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom);
    wait_valid(n);
    chk({tag, " latency"}, n, lat);
    chk({tag, " out_p"}, o_p, p);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    if (s) exp1++; else exp0++;
    chk({tag, " op_count"}, o_cnt, s ? exp1 : exp0);
    chk({tag, " out_valid low"}, o_vld, 0);
    chk({tag, " in_ready"}, o_rdy_in, 1);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 8'hFF, 8'h11, 16'h10EF, 2};
    vecs[1]  = '{1'b1, 8'h03, 8'h30, 16'h0050, 1};
    vecs[2]  = '{1'b1, 8'h55, 8'h00, 16'h0000, 0};
    vecs[3]  = '{1'b1, 8'h01, 8'hFF, 16'h00FF, 2};
    vecs[4]  = '{1'b1, 8'h07, 8'h03, 16'h0009, 1};
    vecs[5]  = '{1'b1, 8'hFF, 8'h0F, 16'h0905, 1};
    vecs[6]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 1};
    vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 16'h9955, 2};
    vecs[8]  = '{1'b1, 8'h0F, 8'hC3, 16'h0451, 2};
    vecs[9]  = '{1'b0, 8'h55, 8'h00, 16'h0000, 2};
    vecs[10] = '{1'b0, 8'h03, 8'h30, 16'h0050, 2};
    vecs[11] = '{1'b0, 8'h07, 8'h03, 16'h0009, 2};

    sel = 1'b1; vld = 1'b0; ordy = 1'b0; a_in = '0; b_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", o_vld, 0);
    chk("reset out_p", o_p, 0);
    chk("reset op_count", o_cnt, 0);
    chk("reset busy", o_busy, 0);
    chk("reset in_ready", o_rdy_in, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, $sformatf("vec%0d", i));

    // Backpressure: result must hold while in_valid pulses are ignored.
    sel = 1'b1; a_in = 8'hFF; b_in = 8'h11; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    wait_valid(n);
    chk("bp latency", n, 2);
    for (int k = 0; k < 5; k++) begin
      vld = k[0]; a_in = 8'h12; b_in = 8'h34;
      @(posedge clk); #1;
      chk("bp out_p stable", o_p, 16'h10EF);
      chk("bp out_valid held", o_vld, 1);
      chk("bp in_ready low", o_rdy_in, 0);
    end
    vld = 1'b1; a_in = 8'h02; b_in = 8'h03; ordy = 1'b1;
    chk("bp in_ready at handshake", o_rdy_in, 0);
    @(posedge clk); #1;
    vld = 1'b0; ordy = 1'b0;
    exp1++;
    chk("bp op_count", o_cnt, exp1);
    chk("bp in_ready after", o_rdy_in, 1);
    chk("bp no overlap accept", o_busy, 0);
    chk("bp out_valid low", o_vld, 0);

    // Reset while in HI: nothing may come out and the counter clears.
    sel = 1'b1; a_in = 8'hFF; b_in = 8'hFF; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    @(posedge clk); #1;
    chk("mid busy before reset", o_busy, 1);
    chk("mid out_valid before reset", o_vld, 0);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", o_vld, 0);
    chk("mid reset out_p", o_p, 0);
    chk("mid reset op_count", o_cnt, 0);
    chk("mid reset busy", o_busy, 0);
    chk("mid reset in_ready", o_rdy_in, 1);
    exp1 = 0; exp0 = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post reset no output", o_vld, 0);
    chk("post reset op_count", o_cnt, 0);
    run_op(1'b1, 8'h01, 8'hFF, 16'h00FF, 2, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
